// File: rtl/serial_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit,
// each CLK_PER_BIT cycles long, with a registered flow-control hold.
module serial_tx #(
  parameter int CLK_PER_BIT = 27,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  output logic       busy,
  input  logic [7:0] data,
  input  logic       new_data
);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_e;

  localparam logic [CTR_SIZE-1:0] CTR_MAX = CTR_SIZE'(CLK_PER_BIT - 1);

  state_e              state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                block_q;
  logic                ctr_done;

  assign ctr_done = (ctr_q == CTR_MAX);
  assign busy     = block_q | (state_q != IDLE);
  assign tx       = tx_q;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    // the bit-period counter free-runs in every non-idle state and wraps at terminal count
    if (state_q != IDLE) ctr_d = ctr_done ? '0 : ctr_q + 1'b1;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        ctr_d = '0;
        bit_d = '0;
        if (!block_q && new_data) begin
          shift_d = data;
          state_d = START_BIT;
          tx_d    = 1'b0;
        end
      end
      START_BIT: if (ctr_done) begin
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (ctr_done) begin
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP_BIT;
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = shift_q[bit_q + 3'd1];
        end
      end
      STOP_BIT: if (ctr_done) state_d = IDLE;
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ctr_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      ctr_q   <= '0;
      bit_q   <= '0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      block_q <= block;
    end
  end

  // payload only matters once a frame is accepted, so it needs no reset
  always_ff @(posedge clk) shift_q <= shift_d;

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 27, meaning clock cycles per serial bit; legal values are integers >= 2.
REQ-002 The block SHALL have parameter CTR_SIZE, default $clog2(CLK_PER_BIT), meaning the bit-period counter width.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port tx  output  1  serial line, idle high.
REQ-006 The block SHALL have port block  input  1  flow-control hold; when high, no new frame may start.
REQ-007 The block SHALL have port busy  output  1  high when a request would not be accepted.
REQ-008 The block SHALL have port data  input  8  byte to send, sampled with new_data.
REQ-009 The block SHALL have port new_data  input  1  single-cycle send request.

Function
REQ-010 The block SHALL implement four states: IDLE, START_BIT, DATA, STOP_BIT.
REQ-011 tx SHALL be driven from a flop, never combinationally.
REQ-012 block SHALL be registered once into block_q, and only block_q SHALL be used internally.
REQ-013 busy SHALL be combinational: busy = block_q OR (state != IDLE).
REQ-014 Accept rule: in a cycle where state = IDLE, block_q = 0 and new_data = 1, data SHALL be latched into a shift register, state -> START_BIT, tx <= 0, and the bit counter and bit index SHALL be cleared.
REQ-015 A new_data pulse seen while busy = 1 SHALL be ignored without side effects, with no queuing.
REQ-016 Changes on data while not accepting SHALL NOT affect the frame in flight.
REQ-017 Each of the START_BIT and STOP_BIT states, and each bit within DATA, SHALL last exactly CLK_PER_BIT cycles, counted by the counter running 0..CLK_PER_BIT-1.
REQ-018 START_BIT to DATA: when the counter reaches CLK_PER_BIT-1, the block SHALL set tx <= shift[0] and state -> DATA.
REQ-019 DATA: at each counter terminal count, the block SHALL increment the bit index and drive the next bit, LSB first.
REQ-020 DATA: after bit index 7 has completed, the block SHALL set tx <= 1 and state -> STOP_BIT.
REQ-021 STOP_BIT: at terminal count, state SHALL go to IDLE with tx remaining 1.
REQ-022 Frame timing: if acceptance occurs in cycle N, tx SHALL be 0 in cycles N+1..N+C, carry data bit k in cycles N+1+(k+1)C..N+(k+2)C, and be 1 in cycles N+1+9C..N+10C, where C = CLK_PER_BIT.
REQ-023 busy SHALL be 1 in cycles N+1..N+10C and 0 in cycle N+1+10C if block_q = 0.
REQ-024 Back-to-back: a new_data pulse in cycle N+1+10C SHALL be accepted, giving exactly one stop-bit period between frames.
REQ-025 block asserted mid-frame SHALL NOT alter the frame in flight; it SHALL only inhibit the next acceptance.
REQ-026 block deasserted SHALL allow acceptance from the second cycle after deassertion, owing to the register delay.
REQ-027 new_data and block rising in the same IDLE cycle SHALL still accept, because block_q is still 0 in that cycle.
REQ-028 The counter SHALL never exceed CLK_PER_BIT-1, and the bit index SHALL wrap 7 -> 0 only on the DATA -> STOP_BIT transition.
REQ-029 An illegal state encoding SHALL return to IDLE on the next clock with tx <= 1.

Reset
REQ-030 While rst = 1, the block SHALL force, immediately and independent of clk: state = IDLE, tx = 1, counter = 0, bit index = 0, block_q = 0, so busy = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with tx high at once, and SHALL NOT produce any partial-frame resumption after release.
REQ-032 The shift register MAY be left unreset.
REQ-033 The first acceptance after reset release SHALL be possible on the first clock edge with rst = 0.

Verification (CLK_PER_BIT = 4 unless noted)
REQ-034 Reset scenario: hold rst for 3 cycles, then release with no stimulus -> tx = 1 and busy = 0 continuously for 50 cycles.
REQ-035 Single-byte scenario: data = 0x55, new_data pulse in cycle N -> tx SHALL give start 0 for 4 cycles, then the bit pattern 1,0,1,0,1,0,1,0 with 4 cycles each, then stop 1 for 4 cycles; busy is high for exactly 40 cycles.
REQ-036 Back-to-back and ignore scenario: send 0xA3, pulse new_data with 0xFF while busy, then pulse 0x3C in the first cycle busy = 0 -> two frames only, 0xA3 then 0x3C, separated by exactly one 4-cycle stop bit, with the 0xFF request dropped.
REQ-037 Flow-control scenario: assert block during the DATA state of a 0x81 frame and pulse new_data after it ends -> the 0x81 frame completes intact, busy stays 1, and there is no new start bit; deassert block -> a request is accepted 2 cycles later.
REQ-038 Mid-frame reset scenario: assert rst asynchronously during bit 3 of 0x00 -> tx = 1 in the same cycle and state = IDLE; after release, a 0x5A frame is sent correctly.
REQ-039 Parameter sweep scenario: run REQ-035 with CLK_PER_BIT = 2 and 27 -> each bit is exactly 2 or 27 cycles respectively, with a total frame length of 10*CLK_PER_BIT.
